call_stack_ctrl: RTL and testbench
==================================

CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 Parameter addr_width, default 4, stack RAM address width; depth = 2**addr_width entries.
REQ-002 Parameter data_width, default 8, program-counter and stack-entry width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 call  input  1  subroutine-call request from decoder; level, held until done.
REQ-006 rtrn  input  1  return request from decoder; level, held until done.
REQ-007 irq  input  1  interrupt-entry request; level, held until done.
REQ-008 i_PC  input  data_width  current program counter.
REQ-009 irq_vec  input  data_width  interrupt handler address.
REQ-010 ram_dout  input  data_width  stack RAM read data, valid one cycle after ram_addr.
REQ-011 ram_addr  output  addr_width  stack RAM address.
REQ-012 ram_din  output  data_width  stack RAM write data.
REQ-013 ram_we  output  1  stack RAM write enable.
REQ-014 pc_load  output  1  one-cycle strobe: PC shall load pc_target.
REQ-015 pc_target  output  data_width  PC value for pc_load.
REQ-016 done  output  1  one-cycle strobe: accepted request completed.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 sp  output  addr_width+1  occupancy count, 0..2**addr_width.
REQ-019 full, empty  output  1 each  sp == 2**addr_width / sp == 0.
REQ-020 fault  output  1  sticky overflow/underflow flag (STACK_FAULT_EN only, else tied 0).

Function
REQ-021 States IDLE, PUSH, POP, FAULT; requests are sampled only in IDLE.
REQ-022 Priority in IDLE: irq > call > rtrn; losing requests stay pending, are not dropped.
REQ-023 IDLE accept of call: latch ram_din = i_PC+1 (modulo 2**data_width), go PUSH.
REQ-024 IDLE accept of irq: latch ram_din = i_PC (unmodified), latch pc_target = irq_vec, go PUSH.
REQ-025 PUSH (1 cycle): ram_we=1, ram_addr = sp[addr_width-1:0], done=1, sp+1, return IDLE; for irq also pc_load=1.
REQ-026 IDLE accept of rtrn: ram_addr = sp-1 (mod 2**addr_width) this cycle, go POP.
REQ-027 POP (1 cycle): pc_target = ram_dout, pc_load=1, done=1, sp-1, return IDLE.
REQ-028 Latency: request high in IDLE at cycle N -> done/pc_load at N+1; next sample at N+2.
REQ-029 ram_we shall be 0 in every state except PUSH; ram_addr holds its value outside IDLE-accept and PUSH.
REQ-030 Requester shall deassert in the cycle after done; a held request is re-accepted.

Reset
REQ-031 rst high at a clock edge: state IDLE, sp 0, empty 1, full 0, fault 0, pc_target 0, ram_din 0.
REQ-032 Outputs during/after reset: ram_we, pc_load, done, busy all 0.
REQ-033 rst mid-PUSH or mid-POP aborts it: no write, no pc_load, no done, sp 0; rst wins over all requests.

Configuration
REQ-034 Macro STACK_FAULT_EN compiles in overflow/underflow protection.
REQ-035 With STACK_FAULT_EN: call/irq accepted while full, or rtrn while empty -> go FAULT, no RAM write, sp unchanged, fault=1.
REQ-036 With STACK_FAULT_EN: FAULT is absorbing (busy=1, no done, requests ignored) until rst.
REQ-037 Without STACK_FAULT_EN: no FAULT state; push when full wraps address and overwrites entry 0, sp saturates at 2**addr_width; pop when empty reads address 2**addr_width-1, sp stays 0; fault tied 0.

Verification
REQ-038 Reset, i_PC=0x10, call 1 -> next cycle ram_we=1, ram_addr=0, ram_din=0x11, done=1, sp=1, pc_load=0.
REQ-039 After REQ-038, rtrn 1 -> ram_addr=0 in accept cycle; next cycle pc_load=1, pc_target=0x11, sp=0, empty=1.
REQ-040 call and irq both high, i_PC=0x20, irq_vec=0xF0 -> irq served first: ram_din=0x20, pc_load=1, pc_target=0xF0; call served next, ram_din=0x21.
REQ-041 16 calls from reset (addr_width=4) -> full=1, sp=16; 17th call: with STACK_FAULT_EN fault=1, busy=1, no write; without it, write to addr 0, sp=16.
REQ-042 rst asserted in PUSH cycle -> ram_we=0, done=0, sp=0 at next edge, empty=1.

Source files
------------

// File: rtl/call_stack_ctrl.sv
// Hardware call/return stack controller: pushes return PCs on call/irq and pops them on return.
// Optional overflow/underflow trapping is compiled in with `define STACK_FAULT_EN.
module call_stack_ctrl #(
  parameter int unsigned addr_width = 4,
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  call,
  input  logic                  rtrn,
  input  logic                  irq,
  input  logic [data_width-1:0] i_PC,
  input  logic [data_width-1:0] irq_vec,
  input  logic [data_width-1:0] ram_dout,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  output logic                  ram_we,
  output logic                  pc_load,
  output logic [data_width-1:0] pc_target,
  output logic                  done,
  output logic                  busy,
  output logic [addr_width:0]   sp,
  output logic                  full,
  output logic                  empty,
  output logic                  fault
);

  localparam int unsigned   DEPTH  = 1 << addr_width;
  localparam logic [addr_width:0] SP_MAX = (addr_width + 1)'(DEPTH);

`ifdef STACK_FAULT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PUSH = 2'd1, S_POP = 2'd2, S_FAULT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PUSH = 2'd1, S_POP = 2'd2} state_t;
`endif

  state_t                r_state;
  logic [addr_width:0]   r_sp;
  logic [addr_width-1:0] r_ram_addr;
  logic [data_width-1:0] r_ram_din;
  logic [data_width-1:0] r_pc_target;
  logic                  r_ram_we;
  logic                  r_pc_load;
  logic                  r_done;
`ifdef STACK_FAULT_EN
  logic                  r_fault;
`endif

  logic                  w_idle;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_take_push;
  logic                  w_take_rtrn;
  logic                  w_pop_ok;
  logic [addr_width-1:0] w_push_addr;
  logic [addr_width-1:0] w_pop_addr;
  logic [data_width-1:0] w_push_data;

  // Request arbitration (irq > call > rtrn) and stack address arithmetic.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_full      = (r_sp == SP_MAX);
    w_empty     = (r_sp == '0);
    w_take_push = w_idle & (irq | call);
    w_take_rtrn = w_idle & ~irq & ~call & rtrn;
`ifdef STACK_FAULT_EN
    w_pop_ok    = ~w_empty;
`else
    w_pop_ok    = 1'b1;
`endif
    w_push_addr = r_sp[addr_width-1:0];
    w_pop_addr  = r_sp[addr_width-1:0] - addr_width'(1);
    w_push_data = irq ? i_PC : data_width'(i_PC + data_width'(1));
  end

  // The pop address is presented in the accept cycle so RAM data lands in the POP cycle.
  assign ram_addr  = (w_take_rtrn & w_pop_ok) ? w_pop_addr : r_ram_addr;
  assign ram_din   = r_ram_din;
  assign ram_we    = r_ram_we  & ~rst;
  assign pc_load   = r_pc_load & ~rst;
  assign done      = r_done    & ~rst;
  assign busy      = (r_state != S_IDLE) & ~rst;
  assign pc_target = (r_state == S_POP) ? ram_dout : r_pc_target;
  assign sp        = r_sp;
  assign full      = w_full;
  assign empty     = w_empty;
`ifdef STACK_FAULT_EN
  assign fault     = r_fault;
`else
  assign fault     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sp        <= '0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_pc_target <= '0;
      r_ram_we    <= 1'b0;
      r_pc_load   <= 1'b0;
      r_done      <= 1'b0;
`ifdef STACK_FAULT_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      r_ram_we  <= 1'b0;
      r_pc_load <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef STACK_FAULT_EN
          if ((w_take_push & w_full) | (w_take_rtrn & w_empty)) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else
`endif
          if (w_take_push) begin
            r_state    <= S_PUSH;
            r_ram_addr <= w_push_addr;
            r_ram_din  <= w_push_data;
            r_ram_we   <= 1'b1;
            r_done     <= 1'b1;
            r_pc_load  <= irq;
            if (irq) begin
              r_pc_target <= irq_vec;
            end
            // Overflow without trapping overwrites entry 0 and leaves sp saturated.
            if (!w_full) begin
              r_sp <= r_sp + (addr_width + 1)'(1);
            end
          end else if (w_take_rtrn) begin
            r_state    <= S_POP;
            r_ram_addr <= w_pop_addr;
            r_pc_load  <= 1'b1;
            r_done     <= 1'b1;
            if (!w_empty) begin
              r_sp <= r_sp - (addr_width + 1)'(1);
            end
          end
        end
        S_PUSH: r_state <= S_IDLE;
        S_POP: begin
          r_pc_target <= ram_dout;
          r_state     <= S_IDLE;
        end
`ifdef STACK_FAULT_EN
        S_FAULT: r_state <= S_FAULT;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Testbench for call_stack_ctrl: directed scenarios then random traffic against a queue-based stack model.
module tb_call_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       call = 1'b0;
  logic       rtrn = 1'b0;
  logic       irq = 1'b0;
  logic [7:0] i_PC = 8'h00;
  logic [7:0] irq_vec = 8'h00;
  logic [7:0] ram_dout = 8'h00;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic       pc_load;
  logic [7:0] pc_target;
  logic       done;
  logic       busy;
  logic [4:0] sp;
  logic       full;
  logic       empty;
  logic       fault;

  call_stack_ctrl #(.addr_width(4), .data_width(8)) dut (
    .clk(clk), .rst(rst), .call(call), .rtrn(rtrn), .irq(irq),
    .i_PC(i_PC), .irq_vec(irq_vec), .ram_dout(ram_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .pc_load(pc_load), .pc_target(pc_target), .done(done), .busy(busy),
    .sp(sp), .full(full), .empty(empty), .fault(fault)
  );

  always #5 clk = ~clk;

  // Synchronous-read stack RAM
  logic [7:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef enum {P_NONE, P_IRQ, P_CALL, P_POP} pend_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] q[$];
  logic [7:0] last_wr [16] = '{default: 8'h00};
  pend_t      pend = P_NONE;
  logic [3:0] pend_addr = 4'd0;
  logic [3:0] held_addr = 4'd0;
  logic [7:0] exp_din = 8'h00;
  logic [7:0] exp_tgt = 8'h00;
  bit         m_fault = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend      = P_NONE;
    held_addr = 4'd0;
    exp_din   = 8'h00;
    exp_tgt   = 8'h00;
    m_fault   = 1'b0;
  endtask

  // One clock cycle: drive request levels, check every output, advance the model.
  task automatic step(input bit r, input bit ri, input bit rc, input bit rr,
                      input logic [7:0] pc, input logic [7:0] vec);
    logic [3:0] pa;
    logic [7:0] v;
    bit         fpush;
    bit         fpop;
    @(posedge clk); #1;
    rst = r; irq = ri; call = rc; rtrn = rr; i_PC = pc; irq_vec = vec;
    #1;
    if (r) begin
      chk("rst_ram_we", ram_we, 0);
      chk("rst_done", done, 0);
      chk("rst_pc_load", pc_load, 0);
      chk("rst_busy", busy, 0);
      model_reset();
      return;
    end
    chk("sp", sp, q.size());
    chk("full", full, q.size() == 16);
    chk("empty", empty, q.size() == 0);
    chk("fault", fault, m_fault);
    chk("ram_din", ram_din, exp_din);
    chk("pc_target", pc_target, exp_tgt);
    if (pend != P_NONE) begin
      chk("op_done", done, 1);
      chk("op_busy", busy, 1);
      chk("op_ram_we", ram_we, pend != P_POP);
      chk("op_pc_load", pc_load, pend != P_CALL);
      chk("op_ram_addr", ram_addr, pend_addr);
      held_addr = pend_addr;
      if (pend != P_POP) last_wr[pend_addr] = exp_din;
      pend = P_NONE;
    end else if (m_fault) begin
      chk("flt_done", done, 0);
      chk("flt_busy", busy, 1);
      chk("flt_ram_we", ram_we, 0);
      chk("flt_pc_load", pc_load, 0);
      chk("flt_ram_addr", ram_addr, held_addr);
    end else begin
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ram_we", ram_we, 0);
      chk("idle_pc_load", pc_load, 0);
      fpush = 1'b0;
      fpop  = 1'b0;
`ifdef STACK_FAULT_EN
      fpush = (q.size() == 16);
      fpop  = (q.size() == 0);
`endif
      if (ri || rc) begin
        chk("push_acc_ram_addr", ram_addr, held_addr);
        if (fpush) begin
          m_fault = 1'b1;
        end else begin
          pa      = (q.size() == 16) ? 4'd0 : 4'(q.size());
          exp_din = ri ? pc : 8'(pc + 8'd1);
          if (ri) exp_tgt = vec;
          if (q.size() == 16) q[0] = exp_din;
          else q.push_back(exp_din);
          pend      = ri ? P_IRQ : P_CALL;
          pend_addr = pa;
        end
      end else if (rr) begin
        if (fpop) begin
          chk("pop_flt_ram_addr", ram_addr, held_addr);
          m_fault = 1'b1;
        end else begin
          pa = (q.size() == 0) ? 4'd15 : 4'(q.size() - 1);
          chk("pop_acc_ram_addr", ram_addr, pa);
          v = (q.size() == 0) ? last_wr[15] : q.pop_back();
          exp_tgt   = v;
          pend      = P_POP;
          pend_addr = pa;
        end
      end else begin
        chk("idle_ram_addr", ram_addr, held_addr);
      end
    end
  endtask

  initial begin
    // Reset and basic call/return round trip
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 1, 0, 8'h10, 8'h00);
    step(0, 0, 0, 0, 8'h10, 8'h00);
    step(0, 0, 0, 1, 8'h33, 8'h00);
    step(0, 0, 0, 0, 8'h33, 8'h00);
    // irq wins over call; the held call is served right after
    step(0, 1, 1, 0, 8'h20, 8'hF0);
    step(0, 0, 1, 0, 8'h20, 8'hF0);
    step(0, 0, 1, 0, 8'h20, 8'hF0);
    step(0, 0, 0, 0, 8'h20, 8'hF0);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 1, 8'h00, 8'h00);
      step(0, 0, 0, 0, 8'h00, 8'h00);
    end
    // Fill to 16 entries, then one more call
    step(1, 0, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 17; k++) begin
      step(0, 0, 1, 0, 8'(8'h40 + k), 8'h00);
      step(0, 0, 0, 0, 8'h00, 8'h00);
    end
    for (int k = 0; k < 18; k++) begin
      step(0, 0, 0, 1, 8'h00, 8'h00);
      step(0, 0, 0, 0, 8'h00, 8'h00);
    end
    // Reset in the middle of a PUSH and of a POP
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 1, 0, 8'h55, 8'h00);
    step(0, 0, 0, 0, 8'h55, 8'h00);
    step(0, 0, 1, 0, 8'h66, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 1, 0, 8'h77, 8'h00);
    step(0, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 1, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 0, 8'h00, 8'h00);
    // Random traffic alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 600; i++) begin
      int  bias;
      bit  rr_r;
      bias = ((i / 60) % 2 == 0) ? 70 : 25;
      rr_r = ($urandom_range(0, 199) == 0);
      step(rr_r, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < bias,
           $urandom_range(0, 99) < (95 - bias), 8'($urandom), 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
